// File: rtl/rom_slot_loader.sv
// rom_slot_loader: boot-ROM loader between an ioctl download port and an SDRAM write port.
//
// The ioctl image is cut into 16 KB slots. Slot n is routed to bank n / SLOTS_PER_BANK and to
// the SDRAM page held in SLOT_MAP[n % SLOTS_PER_BANK]. Accepted bytes go into a small FIFO and
// are written out through a req/ack handshake. busy stays high from the start of a download
// until the FIFO has drained, so it can be ORed into the system reset.
//
// Ports:
//   clk_sys, RESET_n                 clock, synchronous active-low reset
//   ioctl_download/index/wr/addr/dout  download port (one byte per ioctl_wr strobe)
//   mem_req/addr/bank/din, mem_ack   SDRAM write handshake (req held until a 1-cycle ack)
//   busy, done                       loader active / 1-cycle end-of-load pulse
//   slot_loaded                      sticky mask of slots that received at least one byte
//   err_overrun, err_range           sticky: byte dropped on a full FIFO / beyond the last slot
//   csum                             16-bit sum of written bytes (LOADER_CHECKSUM_EN only)
//
// Optional feature: define LOADER_CHECKSUM_EN to add the csum output.
module rom_slot_loader #(
  parameter int unsigned ADDR_W         = 23,
  parameter int unsigned BANK_W         = 1,
  parameter int unsigned NUM_BANKS      = 2,
  parameter int unsigned SLOTS_PER_BANK = 3,
  parameter logic [SLOTS_PER_BANK*(ADDR_W-14)-1:0] SLOT_MAP = {9'h107, 9'h100, 9'h000},
  parameter logic [7:0]  ROM_INDEX      = 8'd0,
  parameter int unsigned FIFO_DEPTH     = 8
) (
  input  logic                                clk_sys,
  input  logic                                RESET_n,
  input  logic                                ioctl_download,
  input  logic [7:0]                          ioctl_index,
  input  logic                                ioctl_wr,
  input  logic [24:0]                         ioctl_addr,
  input  logic [7:0]                          ioctl_dout,
  output logic                                mem_req,
  output logic [ADDR_W-1:0]                   mem_addr,
  output logic [BANK_W-1:0]                   mem_bank,
  output logic [7:0]                          mem_din,
  input  logic                                mem_ack,
  output logic                                busy,
  output logic                                done,
  output logic [NUM_BANKS*SLOTS_PER_BANK-1:0] slot_loaded,
  output logic                                err_overrun,
  output logic                                err_range
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [15:0]                         csum
`endif
);

  localparam int unsigned PageW    = ADDR_W - 14;
  localparam int unsigned NumSlots = NUM_BANKS * SLOTS_PER_BANK;
  localparam int unsigned EntryW   = BANK_W + ADDR_W + 8;
  localparam int unsigned PtrW     = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW     = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StLoad, StDrain, StDone} state_e;

  state_e                state_q;
  logic                  dl_q, busy_q, done_q;
  logic [EntryW-1:0]     fifo_q [FIFO_DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]       count_q;
  logic                  req_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [BANK_W-1:0]     bank_q;
  logic [7:0]            din_q;
  logic [NumSlots-1:0]   loaded_q;
  logic                  ovr_q, rng_q;

  logic [10:0]           slot_idx, sub_idx;
  logic [BANK_W-1:0]     bank_sel;
  logic [PageW-1:0]      page;
  logic                  in_range, idx_ok, start, load_en, push_req, full, pop, push, clr_flags;
  logic [NumSlots-1:0]   set_mask;
  logic [EntryW-1:0]     entry, head;

  always_comb begin
    slot_idx  = ioctl_addr[24:14];
    bank_sel  = BANK_W'(slot_idx / 11'(SLOTS_PER_BANK));
    sub_idx   = slot_idx % 11'(SLOTS_PER_BANK);
    page      = SLOT_MAP[sub_idx*PageW +: PageW];
    in_range  = slot_idx < 11'(NumSlots);
    idx_ok    = ioctl_index == ROM_INDEX;
    start     = ioctl_download & ~dl_q & idx_ok;
    // Bytes are taken in LOAD, or in the very cycle a matching download starts.
    load_en   = (state_q == StLoad) | start;
    push_req  = ioctl_download & ioctl_wr & idx_ok & load_en;
    full      = count_q == CntW'(FIFO_DEPTH);
    pop       = req_q & mem_ack;
    // A pop in the same cycle frees the slot the push needs, even when full.
    push      = push_req & in_range & (~full | pop);
    // Re-rising during DRAIN resumes the same load, so flags are only cleared from IDLE/DONE.
    clr_flags = start & ((state_q == StIdle) | (state_q == StDone));
    for (int unsigned i = 0; i < NumSlots; i++) begin
      set_mask[i] = push & (slot_idx == 11'(i));
    end
    entry     = {bank_sel, page, ioctl_addr[13:0], ioctl_dout};
    head      = fifo_q[rd_ptr_q];
  end

  // FIFO storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk_sys) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= entry;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!RESET_n) begin
      state_q  <= StIdle;
      dl_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      req_q    <= 1'b0;
      addr_q   <= '0;
      bank_q   <= '0;
      din_q    <= '0;
      loaded_q <= '0;
      ovr_q    <= 1'b0;
      rng_q    <= 1'b0;
    end else begin
      dl_q <= ioctl_download;

      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase

      // Outputs are latched from the head when req rises and held until ack.
      if (pop) begin
        req_q <= 1'b0;
      end else if (!req_q && count_q != '0) begin
        req_q  <= 1'b1;
        bank_q <= head[EntryW-1 -: BANK_W];
        addr_q <= head[8 +: ADDR_W];
        din_q  <= head[7:0];
      end

      loaded_q <= (clr_flags ? '0 : loaded_q) | set_mask;
      ovr_q    <= (clr_flags ? 1'b0 : ovr_q) | (push_req & in_range & full & ~pop);
      rng_q    <= (clr_flags ? 1'b0 : rng_q) | (push_req & ~in_range);

      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StLoad;
            busy_q  <= 1'b1;
          end
        end
        StLoad: begin
          if (!ioctl_download) state_q <= StDrain;
        end
        StDrain: begin
          if (start) begin
            state_q <= StLoad;
          end else if (count_q == '0 && !req_q) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        StDone: begin
          if (start) begin
            state_q <= StLoad;
            busy_q  <= 1'b1;
          end else begin
            state_q <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [15:0] csum_q;

  always_ff @(posedge clk_sys) begin
    if (!RESET_n) begin
      csum_q <= '0;
    end else if (clr_flags) begin
      csum_q <= '0;
    end else if (pop) begin
      csum_q <= csum_q + 16'(din_q);
    end
  end

  assign csum = csum_q;
`endif

  assign mem_req     = req_q;
  assign mem_addr    = addr_q;
  assign mem_bank    = bank_q;
  assign mem_din     = din_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign slot_loaded = loaded_q;
  assign err_overrun = ovr_q;
  assign err_range   = rng_q;

endmodule

// File: tb/tb_rom_slot_loader.sv
// Bench for rom_slot_loader: table of ioctl bytes with expected SDRAM bank/address, a scoreboard
// queue filled when bytes are driven and drained by an ack responder, plus short hand sequences
// for overrun, DRAIN re-entry and reset while draining.
module tb_rom_slot_loader;

  logic        clk_sys = 1'b0;
  logic        RESET_n;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        mem_req;
  logic [22:0] mem_addr;
  logic [0:0]  mem_bank;
  logic [7:0]  mem_din;
  logic        mem_ack;
  logic        busy;
  logic        done;
  logic [5:0]  slot_loaded;
  logic        err_overrun;
  logic        err_range;
`ifdef LOADER_CHECKSUM_EN
  logic [15:0] csum;
`endif

  always #5 clk_sys = ~clk_sys;

  rom_slot_loader dut (
    .clk_sys        (clk_sys),
    .RESET_n        (RESET_n),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_bank       (mem_bank),
    .mem_din        (mem_din),
    .mem_ack        (mem_ack),
    .busy           (busy),
    .done           (done),
    .slot_loaded    (slot_loaded),
    .err_overrun    (err_overrun),
    .err_range      (err_range)
`ifdef LOADER_CHECKSUM_EN
    ,
    .csum           (csum)
`endif
  );

  typedef struct {
    logic [24:0] addr;
    logic [7:0]  dout;
    logic        bank;
    logic [22:0] maddr;
  } vec_t;

  typedef struct {
    logic        bank;
    logic [22:0] addr;
    logic [7:0]  data;
  } exp_t;

  vec_t        vecs [10];
  exp_t        sb [$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          wr_cnt = 0;
  int          done_cnt = 0;
  int          req_age;
  bit          ack_en = 1'b0;
  bit          saw_req;
  logic [15:0] sum_m = 16'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  always @(negedge clk_sys) if (done === 1'b1) done_cnt++;

  // SDRAM model: acks 3 cycles after req is seen and checks the write against the scoreboard.
  initial begin
    exp_t e;
    mem_ack = 1'b0;
    req_age = 0;
    forever begin
      @(posedge clk_sys);
      #1;
      mem_ack = 1'b0;
      if (RESET_n && mem_req && ack_en) begin
        req_age++;
        if (req_age >= 3) begin
          wr_cnt++;
          if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_write: got addr %0h want no write", mem_addr);
          end else begin
            e = sb.pop_front();
            chk("wr_addr", 32'(mem_addr), 32'(e.addr));
            chk("wr_bank", 32'(mem_bank), 32'(e.bank));
            chk("wr_data", 32'(mem_din), 32'(e.data));
            sum_m = sum_m + 16'(e.data);
          end
          mem_ack = 1'b1;
          req_age = 0;
        end
      end else begin
        req_age = 0;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic drive_raw(input logic [24:0] a, input logic [7:0] d);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    @(posedge clk_sys);
    #1;
    ioctl_wr   = 1'b0;
  endtask

  task automatic push_exp(input logic b, input logic [22:0] a, input logic [7:0] d);
    exp_t e;
    e.bank = b;
    e.addr = a;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic drive_vec(input vec_t v);
    push_exp(v.bank, v.maddr, v.dout);
    drive_raw(v.addr, v.dout);
  endtask

  task automatic start_dl(input logic [7:0] idx);
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    done_cnt       = 0;
    sum_m          = 16'h0;
    @(posedge clk_sys);
    #1;
  endtask

  task automatic finish_dl(input string name);
    int k;
    ioctl_download = 1'b0;
    k = 0;
    while (done_cnt == 0 && k < 3000) begin
      @(posedge clk_sys);
      #1;
      k++;
    end
    idle(3);
    chk({name, "_done_once"}, 32'(done_cnt), 32'd1);
    chk({name, "_busy_after"}, 32'(busy), 32'd0);
    chk({name, "_sb_empty"}, 32'(sb.size()), 32'd0);
`ifdef LOADER_CHECKSUM_EN
    chk({name, "_csum"}, 32'(csum), 32'(sum_m));
`endif
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  initial begin
    // slot = addr[24:14]; slots 0..2 -> bank 0, 3..5 -> bank 1; pages 0x000, 0x100, 0x107.
    vecs[0] = '{addr: 25'h000_0000, dout: 8'hA5, bank: 1'b0, maddr: 23'h00_0000};
    vecs[1] = '{addr: 25'h000_3FFF, dout: 8'h3C, bank: 1'b0, maddr: 23'h00_3FFF};
    vecs[2] = '{addr: 25'h000_4000, dout: 8'h01, bank: 1'b0, maddr: 23'h40_0000};
    vecs[3] = '{addr: 25'h000_4123, dout: 8'h7E, bank: 1'b0, maddr: 23'h40_0123};
    vecs[4] = '{addr: 25'h000_BFFF, dout: 8'hC3, bank: 1'b0, maddr: 23'h41_FFFF};
    vecs[5] = '{addr: 25'h000_C000, dout: 8'h5A, bank: 1'b1, maddr: 23'h00_0000};
    vecs[6] = '{addr: 25'h000_F00F, dout: 8'h0F, bank: 1'b1, maddr: 23'h00_300F};
    vecs[7] = '{addr: 25'h001_0001, dout: 8'hF0, bank: 1'b1, maddr: 23'h40_0001};
    vecs[8] = '{addr: 25'h001_4002, dout: 8'h99, bank: 1'b1, maddr: 23'h41_C002};
    vecs[9] = '{addr: 25'h001_7FFF, dout: 8'h66, bank: 1'b1, maddr: 23'h41_FFFF};

    RESET_n        = 1'b0;
    ioctl_download = 1'b0;
    ioctl_index    = 8'd0;
    ioctl_wr       = 1'b0;
    ioctl_addr     = '0;
    ioctl_dout     = '0;
    idle(3);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_slot_loaded", 32'(slot_loaded), 32'd0);
    chk("rst_errs", 32'({err_overrun, err_range}), 32'd0);
    RESET_n = 1'b1;
    idle(2);

    // Bank 0 image (slots 0..2), including the first-write latency.
    ack_en = 1'b1;
    wr_cnt = 0;
    start_dl(8'd0);
    chk("a_busy", 32'(busy), 32'd1);
    drive_vec(vecs[0]);
    chk("lat_n1_req", 32'(mem_req), 32'd0);
    idle(1);
    chk("lat_n2_req", 32'(mem_req), 32'd1);
    idle(8);
    for (int i = 1; i < 5; i++) begin
      drive_vec(vecs[i]);
      idle(8);
    end
    finish_dl("img48");
    chk("img48_slots", 32'(slot_loaded), 32'b000111);
    chk("img48_writes", 32'(wr_cnt), 32'd5);
    chk("img48_errs", 32'({err_overrun, err_range}), 32'd0);

    // Out-of-range bytes are dropped and flagged.
    wr_cnt = 0;
    start_dl(8'd0);
    drive_vec(vecs[7]);
    idle(8);
    drive_raw(25'h001_8000, 8'hEE);
    chk("range_flag", 32'(err_range), 32'd1);
    drive_raw(25'h1FF_FFFF, 8'h11);
    idle(8);
    finish_dl("range");
    chk("range_writes", 32'(wr_cnt), 32'd1);
    chk("range_slots", 32'(slot_loaded), 32'b010000);
    chk("range_sticky", 32'(err_range), 32'd1);

    // Download for another index: no activity, flags untouched.
    wr_cnt         = 0;
    done_cnt       = 0;
    saw_req        = 1'b0;
    ioctl_index    = 8'd1;
    ioctl_download = 1'b1;
    idle(1);
    chk("idx1_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 3; i++) begin
      drive_raw(25'(i), 8'h55);
      repeat (4) begin
        if (mem_req) saw_req = 1'b1;
        idle(1);
      end
    end
    ioctl_download = 1'b0;
    idle(5);
    chk("idx1_no_req", 32'(saw_req), 32'd0);
    chk("idx1_writes", 32'(wr_cnt), 32'd0);
    chk("idx1_no_done", 32'(done_cnt), 32'd0);
    chk("idx1_flags_kept", 32'({slot_loaded, err_range}), 32'({6'b010000, 1'b1}));

    // Both banks; starting a new load clears the previous error.
    wr_cnt = 0;
    start_dl(8'd0);
    chk("img96_err_cleared", 32'(err_range), 32'd0);
    for (int i = 0; i < 10; i++) begin
      drive_vec(vecs[i]);
      idle(8);
    end
    finish_dl("img96");
    chk("img96_slots", 32'(slot_loaded), 32'b111111);
    chk("img96_writes", 32'(wr_cnt), 32'd10);
    chk("img96_errs", 32'({err_overrun, err_range}), 32'd0);

    // Ack held off: 9 back-to-back strobes into an 8-deep FIFO, the 9th is dropped.
    ack_en = 1'b0;
    wr_cnt = 0;
    start_dl(8'd0);
    for (int i = 0; i < 9; i++) begin
      if (i < 8) push_exp(1'b0, 23'(i), 8'(8'h10 + i));
      drive_raw(25'(i), 8'(8'h10 + i));
    end
    chk("ovr_flag", 32'(err_overrun), 32'd1);
    chk("ovr_slots", 32'(slot_loaded), 32'b000001);
    chk("ovr_head_req", 32'({mem_req, mem_addr}), 32'({1'b1, 23'h0}));
    ack_en = 1'b1;
    finish_dl("overrun");
    chk("ovr_writes", 32'(wr_cnt), 32'd8);
    chk("ovr_sticky", 32'(err_overrun), 32'd1);

    // Download re-rises during DRAIN: back to LOAD, queued bytes and flags kept.
    ack_en = 1'b0;
    wr_cnt = 0;
    start_dl(8'd0);
    drive_vec(vecs[2]);
    drive_vec(vecs[5]);
    ioctl_download = 1'b0;
    idle(3);
    chk("rerise_drain_busy", 32'({busy, mem_req}), 32'b11);
    ioctl_download = 1'b1;
    idle(1);
    drive_vec(vecs[9]);
    ack_en = 1'b1;
    finish_dl("rerise");
    chk("rerise_writes", 32'(wr_cnt), 32'd3);
    chk("rerise_slots", 32'(slot_loaded), 32'b101010);

    // Reset while draining with 5 bytes queued.
    ack_en = 1'b0;
    start_dl(8'd0);
    for (int i = 0; i < 5; i++) drive_vec(vecs[i]);
    ioctl_download = 1'b0;
    idle(2);
    chk("rstd_pre", 32'({busy, mem_req, slot_loaded}), 32'({2'b11, 6'b000111}));
    RESET_n = 1'b0;
    idle(1);
    chk("rstd_mem_req", 32'(mem_req), 32'd0);
    chk("rstd_busy", 32'(busy), 32'd0);
    chk("rstd_slots", 32'(slot_loaded), 32'd0);
    chk("rstd_errs", 32'({err_overrun, err_range}), 32'd0);
    RESET_n = 1'b1;
    sb.delete();
    ack_en = 1'b1;
    idle(10);
    chk("rstd_fifo_empty", 32'({busy, mem_req}), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
